// File: rtl/bram_player_pkg.sv
// Shared state encodings and width helpers for the multi-voice BRAM sample player.
package bram_player_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DONE} load_state_t;
  typedef enum logic [1:0] {MIX_IDLE, ACCUM, OUTPUT} mix_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int phase_w(input int clip_len, input int frac_bits);
    return $clog2(clip_len) + frac_bits;
  endfunction

  function automatic int acc_w(input int sample_w, input int num_voices);
    return sample_w + cnt_w(num_voices);
  endfunction

endpackage

// File: rtl/voice_phase_acc.sv
// Fractional phase accumulator for one voice; wraps modulo the clip length.
module voice_phase_acc #(
  parameter int PW   = 11,
  parameter int FRAC = 8
) (
  input  logic               clk,
  input  logic               i_clear,
  input  logic               i_tick,
  input  logic               i_enable,
  input  logic [PW-1:0]      i_increment,
  output logic [PW-FRAC-1:0] o_index
);

  logic [PW-1:0] r_phase;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_clear || !i_enable) begin
      r_phase <= '0;
    end else if (i_tick) begin
      r_phase <= r_phase + i_increment;
    end
  end

  assign o_index = r_phase[PW-1:FRAC];

endmodule

// File: rtl/bram_multivoice_player.sv
// Bulk-loads NUM_VOICES clips from BRAM, plays each with its own phase and volume, and mixes them.
// Optional MIX_SATURATE_EN clamps the mix to the sample range instead of wrapping.
module bram_multivoice_player
  import bram_player_pkg::*;
#(
  parameter int  NUM_VOICES      = 4,
  parameter int  CLIP_LEN        = 256,
  parameter int  SAMPLE_W        = 16,
  parameter int  VOLUME_BITS     = 4,
  parameter int  PHASE_FRAC_BITS = 8,
  parameter int  BRAM_LATENCY    = 2,
  parameter int  ADDR_STEP       = 4,
  localparam int PW              = phase_w(CLIP_LEN, PHASE_FRAC_BITS)
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [31:0]                       BRAM_addr,
  output logic                              BRAM_clk,
  output logic [31:0]                       BRAM_din,
  input  logic [31:0]                       BRAM_dout,
  output logic                              BRAM_en,
  output logic                              BRAM_rst,
  output logic [3:0]                        BRAM_we,
  input  logic                              refresh,
  output logic                              loaded,
  input  logic                              sample_tick,
  input  logic [NUM_VOICES-1:0]             voice_en,
  input  logic [NUM_VOICES*PW-1:0]          phase_inc,
  input  logic [NUM_VOICES*VOLUME_BITS-1:0] volume,
  output logic [SAMPLE_W-1:0]               mix_out,
  output logic                              mix_valid
);

  localparam int TOTAL   = NUM_VOICES * CLIP_LEN;
  localparam int IW      = $clog2(CLIP_LEN);
  localparam int AW      = cnt_w(TOTAL);
  localparam int CW      = $clog2(TOTAL + BRAM_LATENCY + 1);
  localparam int VW      = cnt_w(NUM_VOICES);
  localparam int ACC_W   = acc_w(SAMPLE_W, NUM_VOICES);
  localparam int MAX_VOL = 2**VOLUME_BITS - 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  load_state_t r_load_state;
  logic [CW-1:0] r_fill_cnt;
  logic [31:0]   r_bram_addr;
  logic          r_bram_en, r_bram_rst, r_loaded, r_refresh_pend;

  // NOTE: the sample buffer has no reset; contents are only trusted once loaded is high.
  logic [SAMPLE_W-1:0] r_buf [TOTAL];

  mix_state_t                r_mix_state;
  logic [VW-1:0]             r_vcnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic [SAMPLE_W-1:0]       r_mix_out;
  logic                      r_mix_valid;
  logic [NUM_VOICES-1:0]     r_en_lat;
  logic [IW-1:0]             r_idx_lat [NUM_VOICES];
  logic [VOLUME_BITS-1:0]    r_vol_lat [NUM_VOICES];

  logic [IW-1:0]             w_idx [NUM_VOICES];
  logic [CW-1:0]             w_next_word;
  logic [AW-1:0]             w_wr_addr, w_rd_addr;
  logic                      w_refresh_req, w_tick_accept, w_capture;
  logic signed [SAMPLE_W-1:0] w_sample, w_scaled;
  logic [VOLUME_BITS-1:0]    w_shamt;
  logic signed [ACC_W-1:0]   w_term, w_acc_next;
  logic [SAMPLE_W-1:0]       w_mix_result;
  logic                      w_unused_dout;

  assign w_refresh_req = refresh || r_refresh_pend;
  assign w_tick_accept = sample_tick && r_loaded && !w_refresh_req && (r_mix_state == MIX_IDLE);
  assign w_next_word   = r_fill_cnt + 1'b1;
  assign w_wr_addr     = AW'(r_fill_cnt - CW'(BRAM_LATENCY));
  assign w_capture     = (r_load_state == FILL) && (r_fill_cnt >= CW'(BRAM_LATENCY)) &&
                         (r_fill_cnt < CW'(TOTAL + BRAM_LATENCY));
  assign w_unused_dout = ^BRAM_dout[31:SAMPLE_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_state   <= IDLE;
      r_fill_cnt     <= '0;
      r_bram_addr    <= '0;
      r_bram_en      <= 1'b0;
      r_bram_rst     <= 1'b1;
      r_loaded       <= 1'b0;
      r_refresh_pend <= 1'b0;
    end else begin
      r_bram_rst <= 1'b0;
      case (r_load_state)
        IDLE: begin
          r_load_state <= FILL;
          r_fill_cnt   <= '0;
          r_bram_addr  <= '0;
          r_bram_en    <= 1'b1;
        end
        FILL: begin
          r_fill_cnt <= w_next_word;
          if (w_next_word < CW'(TOTAL)) begin
            r_bram_addr <= 32'(w_next_word) * 32'(ADDR_STEP);
          end else begin
            r_bram_addr <= '0;
            r_bram_en   <= 1'b0;
          end
          if (r_fill_cnt == CW'(TOTAL + BRAM_LATENCY)) begin
            r_load_state <= DONE;
            r_loaded     <= 1'b1;
          end
        end
        DONE: begin
          // A refresh waits for any in-flight mix so it finishes from the old buffer.
          if (w_refresh_req) begin
            if (r_mix_state == MIX_IDLE || r_mix_state == OUTPUT) begin
              r_load_state   <= IDLE;
              r_loaded       <= 1'b0;
              r_refresh_pend <= 1'b0;
            end else begin
              r_refresh_pend <= 1'b1;
            end
          end
        end
        default: r_load_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_buf[w_wr_addr] <= BRAM_dout[SAMPLE_W-1:0];
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_phase_acc #(.PW(PW), .FRAC(PHASE_FRAC_BITS)) u_phase (
      .clk         (clk),
      .i_clear     (rst),
      .i_tick      (w_tick_accept),
      .i_enable    (voice_en[v]),
      .i_increment (phase_inc[v*PW +: PW]),
      .o_index     (w_idx[v])
    );
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    w_rd_addr    = AW'(r_vcnt) * AW'(CLIP_LEN) + AW'(r_idx_lat[r_vcnt]);
    w_sample     = r_buf[w_rd_addr];
    w_shamt      = VOLUME_BITS'(MAX_VOL) - r_vol_lat[r_vcnt];
    w_scaled     = w_sample >>> w_shamt;
    w_term       = '0;
    if (r_en_lat[r_vcnt] && (r_vol_lat[r_vcnt] != '0)) begin
      w_term = {{(ACC_W-SAMPLE_W){w_scaled[SAMPLE_W-1]}}, w_scaled};
    end
    w_acc_next   = r_acc + w_term;
    w_mix_result = w_acc_next[SAMPLE_W-1:0];
`ifdef MIX_SATURATE_EN
    if (w_acc_next > SAT_MAX) begin
      w_mix_result = SAT_MAX[SAMPLE_W-1:0];
    end else if (w_acc_next < SAT_MIN) begin
      w_mix_result = SAT_MIN[SAMPLE_W-1:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mix_state <= MIX_IDLE;
      r_vcnt      <= '0;
      r_acc       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_en_lat    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_idx_lat[v] <= '0;
        r_vol_lat[v] <= '0;
      end
    end else begin
      r_mix_valid <= 1'b0;
      case (r_mix_state)
        MIX_IDLE: begin
          if (w_tick_accept) begin
            r_mix_state <= ACCUM;
            r_vcnt      <= '0;
            r_acc       <= '0;
            r_en_lat    <= voice_en;
            for (int v = 0; v < NUM_VOICES; v++) begin
              r_idx_lat[v] <= w_idx[v];
              r_vol_lat[v] <= volume[v*VOLUME_BITS +: VOLUME_BITS];
            end
          end
        end
        ACCUM: begin
          r_acc  <= w_acc_next;
          r_vcnt <= r_vcnt + 1'b1;
          if (r_vcnt == VW'(NUM_VOICES - 1)) begin
            r_mix_state <= OUTPUT;
            r_mix_out   <= w_mix_result;
            r_mix_valid <= 1'b1;
          end
        end
        OUTPUT:  r_mix_state <= MIX_IDLE;
        default: r_mix_state <= MIX_IDLE;
      endcase
    end
  end

  assign BRAM_addr = r_bram_addr;
  assign BRAM_clk  = clk;
  assign BRAM_din  = '0;
  assign BRAM_en   = r_bram_en;
  assign BRAM_rst  = r_bram_rst;
  assign BRAM_we   = '0;
  assign loaded    = r_loaded;
  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;

endmodule

// File: tb/tb_bram_multivoice_player.sv
// Directed bench for bram_multivoice_player: 2 voices x 8 samples with a 2-cycle BRAM model.
`timescale 1ns/1ps
module tb_bram_multivoice_player;

  localparam int NV    = 2;
  localparam int CL    = 8;
  localparam int SW    = 16;
  localparam int VB    = 4;
  localparam int FRAC  = 8;
  localparam int LAT   = 2;
  localparam int STEP  = 4;
  localparam int PW    = 11;
  localparam int TOTAL = NV * CL;
  // From reset release: one IDLE cycle, TOTAL issue cycles, LAT cycles of drain, one closing cycle.
  localparam int FILL_CYCLES = 1 + TOTAL + LAT + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       BRAM_addr, BRAM_din, BRAM_dout;
  logic              BRAM_clk, BRAM_en, BRAM_rst;
  logic [3:0]        BRAM_we;
  logic              refresh, loaded, sample_tick, mix_valid;
  logic [NV-1:0]     voice_en;
  logic [NV*PW-1:0]  phase_inc;
  logic [NV*VB-1:0]  volume;
  logic [SW-1:0]     mix_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [TOTAL];
  logic [31:0] addr_q;

  always #5 clk = ~clk;

  // Two-stage BRAM: address registered, then data registered.
  always @(posedge clk) begin
    addr_q    <= BRAM_addr;
    BRAM_dout <= mem[addr_q[5:2]];
  end

  bram_multivoice_player #(
    .NUM_VOICES(NV), .CLIP_LEN(CL), .SAMPLE_W(SW), .VOLUME_BITS(VB),
    .PHASE_FRAC_BITS(FRAC), .BRAM_LATENCY(LAT), .ADDR_STEP(STEP)
  ) dut (
    .clk(clk), .rst(rst), .BRAM_addr(BRAM_addr), .BRAM_clk(BRAM_clk), .BRAM_din(BRAM_din),
    .BRAM_dout(BRAM_dout), .BRAM_en(BRAM_en), .BRAM_rst(BRAM_rst), .BRAM_we(BRAM_we),
    .refresh(refresh), .loaded(loaded), .sample_tick(sample_tick), .voice_en(voice_en),
    .phase_inc(phase_inc), .volume(volume), .mix_out(mix_out), .mix_valid(mix_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_loaded(output int n);
    n = 0;
    for (int k = 1; k <= 100 && n == 0; k++) begin
      @(negedge clk);
      if (loaded) n = k;
    end
  endtask

  // One tick held for 'hold' cycles; checks latency, value and single-cycle strobe.
  task automatic tick(input int hold, input logic [15:0] exp, input string tag);
    int lat;
    lat = 0;
    sample_tick = 1'b1;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (k == hold) sample_tick = 1'b0;
      if (mix_valid) lat = k;
    end
    sample_tick = 1'b0;
    check({tag, " latency"}, lat, NV + 1);
    check({tag, " value"}, mix_out, exp);
    @(negedge clk);
    check({tag, " strobe"}, mix_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, saw_valid, found;
    rst = 1'b1; refresh = 1'b0; sample_tick = 1'b0;
    voice_en = '0; phase_inc = '0; volume = '0;
    for (int i = 0; i < TOTAL; i++) mem[i] = 32'(i);
    repeat (3) @(negedge clk);

    check("reset addr", BRAM_addr, 32'd0);
    check("reset en", BRAM_en, 1'b0);
    check("reset bram_rst", BRAM_rst, 1'b1);
    check("reset loaded", loaded, 1'b0);
    check("reset mix_out", mix_out, 16'd0);
    check("reset mix_valid", mix_valid, 1'b0);
    check("bram_we tied", BRAM_we, 4'd0);

    // Initial fill with word n = n.
    rst = 1'b0;
    @(negedge clk);
    check("fill word0 addr", BRAM_addr, 32'd0);
    check("fill word0 en", BRAM_en, 1'b1);
    check("bram_rst released", BRAM_rst, 1'b0);
    wait_loaded(n);
    check("initial fill cycles", n + 1, FILL_CYCLES);
    check("en low in DONE", BRAM_en, 1'b0);

    // Voice 0 at unit rate; tick 4 is held two cycles and its second cycle must be dropped.
    voice_en = 2'b01; phase_inc = {11'h000, 11'h100}; volume = {4'd0, 4'd15};
    for (int i = 0; i < 10; i++) tick((i == 4) ? 2 : 1, 16'(i % 8), $sformatf("v0 unit %0d", i));

    // Voice 1 alone reads the second half of the buffer.
    voice_en = 2'b10; phase_inc = {11'h100, 11'h000}; volume = {4'd15, 4'd0};
    for (int i = 0; i < 8; i++) tick(1, 16'(8 + i), $sformatf("v1 unit %0d", i));

    // Half rate: each index plays twice.
    voice_en = 2'b01; phase_inc = {11'h000, 11'h080}; volume = {4'd0, 4'd15};
    for (int i = 0; i < 6; i++) tick(1, 16'(i / 2), $sformatf("v0 half %0d", i));

    // New content, refresh in DONE, ignored refresh and tick during the refill.
    mem[0] = 32'hDEAD7FFF; mem[1] = 32'd20; mem[2] = 32'h0000FFEC; mem[4] = 32'h00008000;
    mem[8] = 32'h12347FFF; mem[10] = 32'h00008000;
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    check("refresh clears loaded", loaded, 1'b0);
    saw_valid = 0; n = 0;
    for (int k = 2; k <= 100 && n == 0; k++) begin
      if (k == 6) refresh = 1'b1;
      if (k == 7) refresh = 1'b0;
      if (k == 9) sample_tick = 1'b1;
      if (k == 10) sample_tick = 1'b0;
      @(negedge clk);
      if (mix_valid) saw_valid = 1;
      if (loaded) n = k;
    end
    check("refill cycles", n, FILL_CYCLES + 1);
    check("no mix_valid while unloaded", saw_valid, 0);
    check("mix_out held while unloaded", mix_out, 16'd2);

    // Volume scaling on voice 0; the refill tick must not have advanced anything.
    voice_en = 2'b00;
    @(negedge clk);
    voice_en = 2'b01; phase_inc = {11'h000, 11'h100}; volume = {4'd0, 4'd14};
    tick(1, 16'h3FFF, "vol14 max");
    tick(1, 16'h000A, "vol14 pos");
    tick(1, 16'hFFF6, "vol14 neg");
    volume = {4'd0, 4'd0};
    tick(1, 16'h0000, "vol0 mute");
    volume = {4'd0, 4'd1};
    tick(1, 16'hFFFE, "vol1 neg");

    // Two-voice mix at unity, including both overflow directions.
    voice_en = 2'b00;
    @(negedge clk);
    voice_en = 2'b11; phase_inc = {11'h100, 11'h100}; volume = {4'd15, 4'd15};
`ifdef MIX_SATURATE_EN
    tick(1, 16'h7FFF, "mix pos overflow");
    tick(1, 16'h001D, "mix in range");
    tick(1, 16'h8000, "mix neg overflow");
`else
    tick(1, 16'hFFFE, "mix pos overflow");
    tick(1, 16'h001D, "mix in range");
    tick(1, 16'h7FEC, "mix neg overflow");
`endif

    // Refresh while a mix is in flight: mix completes, then loaded drops.
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0; refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
    @(negedge clk);
    check("inflight mix_valid", mix_valid, 1'b1);
    check("inflight mix_out", mix_out, 16'd14);
    check("inflight loaded held", loaded, 1'b1);
    @(negedge clk);
    check("loaded drops after output", loaded, 1'b0);

    // Reset at fill word 5, then a clean restart.
    found = 0;
    for (int k = 1; k <= 50 && found == 0; k++) begin
      @(negedge clk);
      if (BRAM_en && BRAM_addr == 32'd20) found = 1;
    end
    check("reached fill word 5", found, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midfill rst addr", BRAM_addr, 32'd0);
    check("midfill rst loaded", loaded, 1'b0);
    check("midfill rst en", BRAM_en, 1'b0);
    check("midfill rst bram_rst", BRAM_rst, 1'b1);
    check("midfill rst mix_out", mix_out, 16'd0);
    rst = 1'b0;
    wait_loaded(n);
    check("restart fill cycles", n, FILL_CYCLES);
    voice_en = 2'b01; phase_inc = {11'h000, 11'h100}; volume = {4'd0, 4'd15};
    tick(1, 16'h7FFF, "after restart idx0");
    tick(1, 16'h0014, "after restart idx1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
